// File: rtl/bb_shift_accumulator.sv
// BitBlade shift-accumulator: sequences 2b x 2b brick products of one
// variable-precision dot product and shift-accumulates them into a wide sum.
module bb_shift_accumulator #(
    parameter int ACC_W = 32,
    parameter int LEN_W = 8
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             START,
    input  logic [1:0]       PREC_I,
    input  logic [1:0]       PREC_W,
    input  logic             SIGNED_I,
    input  logic             SIGNED_W,
    input  logic [LEN_W-1:0] LEN,
    output logic [1:0]       IDX_I,
    output logic [1:0]       IDX_W,
    output logic             SIGN_I,
    output logic             SIGN_W,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [5:0]       MUL,
    output logic             BUSY,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [ACC_W-1:0] OUT_ACC
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  r_state;
    logic [1:0]              r_ni_m1;
    logic [1:0]              r_nw_m1;
    logic                    r_signed_i;
    logic                    r_signed_w;
    logic [LEN_W-1:0]        r_len_m1;
    logic [1:0]              r_i;
    logic [1:0]              r_j;
    logic [LEN_W-1:0]        r_e;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_sign_i;
    logic                    r_sign_w;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_busy;

    // Pair count minus one: 2b -> 1 pair, 4b -> 2 pairs, 8b (codes 2,3) -> 4 pairs.
    function automatic logic [1:0] f_pairs_m1(input logic [1:0] prec);
        case (prec)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic signed [ACC_W-1:0] f_brick_term(
        input logic [5:0] mul,
        input logic [1:0] i,
        input logic [1:0] j
    );
        logic signed [ACC_W-1:0] ext;
        logic [2:0]              pos;
        ext = {{(ACC_W-6){mul[5]}}, mul};
        pos = {1'b0, i} + {1'b0, j};
        return ext <<< {pos, 1'b0};
    endfunction

    logic       w_beat;
    logic       w_i_last;
    logic       w_j_last;
    logic       w_e_last;
    logic       w_op_last;
    logic [1:0] w_i_nxt;
    logic [1:0] w_j_nxt;

    assign w_beat    = r_in_ready & IN_VALID;
    assign w_i_last  = (r_i == r_ni_m1);
    assign w_j_last  = (r_j == r_nw_m1);
    assign w_e_last  = (r_e == r_len_m1);
    assign w_op_last = w_i_last & w_j_last & w_e_last;
    assign w_i_nxt   = w_i_last ? 2'd0 : r_i + 2'd1;
    assign w_j_nxt   = w_i_last ? (w_j_last ? 2'd0 : r_j + 2'd1) : r_j;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state     <= S_IDLE;
            r_ni_m1     <= '0;
            r_nw_m1     <= '0;
            r_signed_i  <= 1'b0;
            r_signed_w  <= 1'b0;
            r_len_m1    <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_e         <= '0;
            r_acc       <= '0;
            r_sign_i    <= 1'b0;
            r_sign_w    <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_state    <= S_RUN;
                        r_ni_m1    <= f_pairs_m1(PREC_I);
                        r_nw_m1    <= f_pairs_m1(PREC_W);
                        r_signed_i <= SIGNED_I;
                        r_signed_w <= SIGNED_W;
                        // LEN=0 wraps to all ones, i.e. 2^LEN_W elements.
                        r_len_m1   <= LEN - 1'b1;
                        r_i        <= '0;
                        r_j        <= '0;
                        r_e        <= '0;
                        r_acc      <= '0;
                        r_sign_i   <= SIGNED_I & (f_pairs_m1(PREC_I) == 2'd0);
                        r_sign_w   <= SIGNED_W & (f_pairs_m1(PREC_W) == 2'd0);
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_beat) begin
                        r_acc    <= r_acc + f_brick_term(MUL, r_i, r_j);
                        r_i      <= w_i_nxt;
                        r_j      <= w_j_nxt;
                        r_sign_i <= r_signed_i & (w_i_nxt == r_ni_m1);
                        r_sign_w <= r_signed_w & (w_j_nxt == r_nw_m1);
                        if (w_i_last && w_j_last)
                            r_e <= w_e_last ? '0 : r_e + 1'b1;
                        if (w_op_last) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (OUT_READY) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign IDX_I     = r_i;
    assign IDX_W     = r_j;
    assign SIGN_I    = r_sign_i;
    assign SIGN_W    = r_sign_w;
    assign IN_READY  = r_in_ready;
    assign BUSY      = r_busy;
    assign OUT_VALID = r_out_valid;
    assign OUT_ACC   = r_acc;

endmodule

// File: tb/tb_bb_shift_accumulator.sv
// Scoreboard bench for bb_shift_accumulator: brick order, sign controls,
// shift-accumulated result, handshake timing, mid-run reset and ignored START.
module tb_bb_shift_accumulator;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        START;
    logic [1:0]  PREC_I;
    logic [1:0]  PREC_W;
    logic        SIGNED_I;
    logic        SIGNED_W;
    logic [7:0]  LEN;
    logic [1:0]  IDX_I;
    logic [1:0]  IDX_W;
    logic        SIGN_I;
    logic        SIGN_W;
    logic        IN_VALID;
    logic        IN_READY;
    logic [5:0]  MUL;
    logic        BUSY;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_ACC;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb[$];
    int          mq[$];

    always #5 CLK = ~CLK;

    bb_shift_accumulator #(.ACC_W(32), .LEN_W(8)) dut (
        .CLK(CLK), .RSTn(RSTn), .START(START),
        .PREC_I(PREC_I), .PREC_W(PREC_W), .SIGNED_I(SIGNED_I), .SIGNED_W(SIGNED_W),
        .LEN(LEN), .IDX_I(IDX_I), .IDX_W(IDX_W), .SIGN_I(SIGN_I), .SIGN_W(SIGN_W),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .MUL(MUL), .BUSY(BUSY),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_ACC(OUT_ACC)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int npairs(input logic [1:0] p);
        return (p == 2'd0) ? 1 : ((p == 2'd1) ? 2 : 4);
    endfunction

    // Drives one full operation using MUL values from mq; the expected sum
    // is built from the bench's own brick ordering and pushed to sb.
    task automatic run_op(input logic [1:0] pi, input logic [1:0] pw,
                          input logic si, input logic sw, input logic [7:0] len,
                          input int gap, input bit poke, input int ready_delay,
                          input string name);
        int          ni;
        int          nw;
        int          ne;
        logic [31:0] exp_acc;
        logic [31:0] ext;
        logic [31:0] expv;
        logic [5:0]  m6;
        logic [7:0]  vexp;
        logic [7:0]  vact;
        ni = npairs(pi);
        nw = npairs(pw);
        ne = (len == 8'd0) ? 256 : int'(len);
        exp_acc = '0;
        PREC_I = pi; PREC_W = pw; SIGNED_I = si; SIGNED_W = sw; LEN = len;
        START = 1'b1;
        tick();
        START = 1'b0;
        checks++;
        if ({BUSY, IN_READY, OUT_VALID} !== 3'b110) begin
            failures++;
            $display("FAIL %s start: busy/in_ready/out_valid=%b required 110", name, {BUSY, IN_READY, OUT_VALID});
        end
        for (int e = 0; e < ne; e++) begin
            for (int j = 0; j < nw; j++) begin
                for (int i = 0; i < ni; i++) begin
                    m6 = 6'(mq.pop_front());
                    ext = {{26{m6[5]}}, m6};
                    exp_acc = exp_acc + (ext << (2 * (i + j)));
                    vexp = {2'(i), 2'(j), si & (i == ni - 1), sw & (j == nw - 1), 1'b0, 1'b1};
                    vact = {IDX_I, IDX_W, SIGN_I, SIGN_W, OUT_VALID, IN_READY};
                    checks++;
                    if (vact !== vexp) begin
                        failures++;
                        $display("FAIL %s beat e=%0d j=%0d i=%0d: idx_i,idx_w,sign_i,sign_w,ov,ir=%b required %b",
                                 name, e, j, i, vact, vexp);
                    end
                    if (poke) begin
                        START = 1'b1; PREC_I = ~pi; PREC_W = ~pw; SIGNED_I = ~si; SIGNED_W = ~sw; LEN = len + 8'd1;
                    end
                    IN_VALID = 1'b1;
                    MUL = m6;
                    tick();
                    IN_VALID = 1'b0;
                    MUL = $urandom_range(0, 63);
                    START = 1'b0;
                    if (!(e == ne - 1 && j == nw - 1 && i == ni - 1))
                        repeat (gap) tick();
                end
            end
        end
        sb.push_back(exp_acc);
        checks++;
        if ({OUT_VALID, IN_READY, BUSY} !== 3'b101) begin
            failures++;
            $display("FAIL %s done timing: out_valid/in_ready/busy=%b required 101", name, {OUT_VALID, IN_READY, BUSY});
        end
        expv = sb.pop_front();
        checks++;
        if (OUT_ACC !== expv) begin
            failures++;
            $display("FAIL %s result: OUT_ACC=%0d (0x%h) required %0d (0x%h)",
                     name, $signed(OUT_ACC), OUT_ACC, $signed(expv), expv);
        end
        for (int d = 0; d < ready_delay; d++) begin
            OUT_READY = 1'b0;
            if (poke) START = 1'b1;
            tick();
            checks++;
            if (OUT_VALID !== 1'b1 || OUT_ACC !== expv) begin
                failures++;
                $display("FAIL %s hold cycle %0d: out_valid=%b OUT_ACC=0x%h required 1 0x%h",
                         name, d, OUT_VALID, OUT_ACC, expv);
            end
        end
        OUT_READY = 1'b1;
        if (poke) START = 1'b1;
        tick();
        OUT_READY = 1'b0;
        START = 1'b0;
        checks++;
        if ({OUT_VALID, BUSY, IN_READY} !== 3'b000) begin
            failures++;
            $display("FAIL %s after handshake: out_valid/busy/in_ready=%b required 000",
                     name, {OUT_VALID, BUSY, IN_READY});
        end
    endtask

    task automatic test_reset();
        RSTn = 1'b0; START = 1'b0; PREC_I = '0; PREC_W = '0; SIGNED_I = 1'b0; SIGNED_W = 1'b0;
        LEN = 8'd1; IN_VALID = 1'b0; MUL = '0; OUT_READY = 1'b0;
        repeat (3) tick();
        checks++;
        if ({IDX_I, IDX_W, SIGN_I, SIGN_W, IN_READY, BUSY, OUT_VALID} !== 9'b0 || OUT_ACC !== 32'd0) begin
            failures++;
            $display("FAIL reset: outs=%b acc=0x%h required all zero",
                     {IDX_I, IDX_W, SIGN_I, SIGN_W, IN_READY, BUSY, OUT_VALID}, OUT_ACC);
        end
        RSTn = 1'b1;
        tick();
    endtask

    task automatic test_2b_unsigned();
        mq = '{9};
        run_op(2'd0, 2'd0, 1'b0, 1'b0, 8'd1, 0, 1'b0, 0, "t1_2bx2b");
    endtask

    task automatic test_8b_signed();
        mq.delete();
        for (int k = 0; k < 15; k++) mq.push_back(0);
        mq.push_back(4);
        run_op(2'd2, 2'd3, 1'b1, 1'b1, 8'd1, 0, 1'b0, 1, "t2_8bx8b");
    endtask

    task automatic test_mixed_prec();
        mq = '{9, -3};
        run_op(2'd1, 2'd0, 1'b1, 1'b0, 8'd1, 0, 1'b0, 0, "t3_4bx2b");
    endtask

    task automatic test_gaps_backpressure();
        mq = '{-4, 4, -2};
        run_op(2'd0, 2'd0, 1'b1, 1'b1, 8'd3, 2, 1'b0, 5, "t4_gaps");
    endtask

    task automatic test_reset_midrun();
        PREC_I = 2'd2; PREC_W = 2'd2; SIGNED_I = 1'b1; SIGNED_W = 1'b1; LEN = 8'd1;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int b = 0; b < 7; b++) begin
            IN_VALID = 1'b1;
            MUL = $urandom_range(1, 63);
            tick();
        end
        #2 RSTn = 1'b0;
        #1;
        checks++;
        if ({IDX_I, IDX_W, SIGN_I, SIGN_W, IN_READY, BUSY, OUT_VALID} !== 9'b0 || OUT_ACC !== 32'd0) begin
            failures++;
            $display("FAIL midrun_reset: outs=%b acc=0x%h required all zero",
                     {IDX_I, IDX_W, SIGN_I, SIGN_W, IN_READY, BUSY, OUT_VALID}, OUT_ACC);
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        tick();
        RSTn = 1'b1;
        repeat (3) tick();
        OUT_READY = 1'b0;
        checks++;
        if ({OUT_VALID, BUSY} !== 2'b00) begin
            failures++;
            $display("FAIL midrun_reset idle: out_valid/busy=%b required 00", {OUT_VALID, BUSY});
        end
        mq = '{1};
        run_op(2'd0, 2'd0, 1'b0, 1'b0, 8'd1, 0, 1'b0, 0, "t5_after_reset");
    endtask

    task automatic test_start_ignored_len0();
        mq.delete();
        for (int k = 0; k < 256; k++) mq.push_back(int'($urandom_range(0, 63)));
        run_op(2'd0, 2'd0, 1'b1, 1'b0, 8'd0, 0, 1'b1, 2, "t6_len0_start");
    endtask

    initial begin
        test_reset();
        test_2b_unsigned();
        test_8b_signed();
        test_mixed_prec();
        test_gaps_backpressure();
        test_reset_midrun();
        test_start_ignored_len0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/bb_shift_accumulator.md
Name: bb_shift_accumulator

Overview:
- Downstream neighbour of the 2b reconfigurable brick multiplier in the BitBlade PE.
- Sequences one variable-precision dot product (input and weight each 2/4/8 bit) as a series of 2b x 2b brick products.
- Drives the multiplier's per-brick sign controls and pair indices, consumes its 6-bit product, and shift-accumulates it into a wide accumulator.
- Returns the final sum over a valid/ready handshake.

Parameters:
- ACC_W, 32, accumulator and result width (min 24).
- LEN_W, 8, width of element-count field.

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- START  in  1  one-cycle request to begin; sampled only in IDLE.
- PREC_I  in  2  input precision: 0=2b, 1=4b, 2=8b, 3=8b.
- PREC_W  in  2  weight precision, same encoding.
- SIGNED_I  in  1  input operand is two's complement.
- SIGNED_W  in  1  weight operand is two's complement.
- LEN  in  LEN_W  element count; 0 means 2^LEN_W.
- IDX_I  out  2  input bit-pair index of the current brick.
- IDX_W  out  2  weight bit-pair index of the current brick.
- SIGN_I  out  1  to multiplier SignI.
- SIGN_W  out  1  to multiplier SignW.
- IN_VALID  in  1  MUL product valid.
- IN_READY  out  1  block accepts product.
- MUL  in  6  brick product, two's complement.
- BUSY  out  1  state != IDLE.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  result consumer ready.
- OUT_ACC  out  ACC_W  signed result.

Behaviour:
- Reset (async, RSTn low): state=IDLE; accumulator=0; counters=0; IDX_I=IDX_W=0; SIGN_I=SIGN_W=0; IN_READY=0; OUT_VALID=0; BUSY=0; OUT_ACC=0.
- Reset mid-RUN/DONE aborts the operation; no partial result is emitted.
- Pair counts from the precision fields:
  - NI = 1/2/4 for PREC_I = 0/1/2; code 3 gives 4.
  - NW from PREC_W, same mapping.
- States:
  - IDLE --START--> RUN. Latches PREC_I, PREC_W, SIGNED_I, SIGNED_W and LEN; clears accumulator and counters.
  - RUN --last beat accepted--> DONE.
  - DONE --OUT_VALID & OUT_READY--> IDLE.
  - START outside IDLE is ignored.
- Brick ordering in RUN, one brick per accepted beat:
  - i (input pair) increments fastest, 0..NI-1.
  - Then j (weight pair), 0..NW-1.
  - Then element e, 0..LEN-1 (wraps i, j to 0).
  - Total beats = LEN*NI*NW.
- Registered outputs: IDX_I=i, IDX_W=j, SIGN_I = SIGNED_I & (i==NI-1), SIGN_W = SIGNED_W & (j==NW-1). They change only on an accepted beat.
- IN_READY = 1 exactly in RUN. Beat = IN_VALID & IN_READY.
- IN_VALID low stalls all counters and the accumulator; gaps are legal.
- Per beat: acc <= acc + (sext_ACC_W(MUL) << 2*(i+j)).
  - Max shift is 12.
  - Arithmetic wraps modulo 2^ACC_W with no saturation.
- Timing around the last beat:
  - The last beat is accepted in cycle N.
  - OUT_VALID=1 in cycle N+1, with OUT_ACC = final acc.
  - IN_READY=0 from cycle N+1.
- DONE holds OUT_VALID and OUT_ACC stable until OUT_READY. OUT_VALID drops the cycle after the handshake.
- START in the same cycle as the output handshake is ignored; it is accepted only from IDLE.
- LEN=1 with 2b x 2b is a single beat; the result follows 1 cycle later.

Test Plan:
1. PREC 2b/2b unsigned, LEN=1.
   - Stimulus: MUL=9 (3*3).
   - Required: SIGN_I=SIGN_W=0; OUT_ACC=9 one cycle after the beat.
2. PREC 8b/8b signed, LEN=1, A=W=0x80.
   - Stimulus: 16 beats; MUL=4 at (i=3,j=3), else 0.
   - Required: SIGN_I=1 only when i=3; SIGN_W=1 only when j=3; OUT_ACC=16384.
3. PREC_I=4b signed, PREC_W=2b unsigned, A=-1, W=3.
   - Stimulus: beats MUL=9 (i=0), then MUL=-3 (i=1).
   - Required: OUT_ACC=-3 (0xFFFFFFFD).
4. LEN=3, 2b/2b signed.
   - Stimulus: products -4, 4, -2 with IN_VALID gaps of 2 cycles; OUT_READY held low 5 cycles.
   - Required: OUT_ACC=-2 held stable, OUT_VALID high throughout; returns to IDLE after the handshake.
5. RSTn pulsed low at beat 7 of an 8b/8b run.
   - Required: all outputs reach reset values immediately; no OUT_VALID.
   - Then a new START runs a clean 2b/2b op: MUL=1 -> OUT_ACC=1.
6. START asserted during RUN and during DONE.
   - Required: ignored, config unchanged, beat count unchanged.
   - LEN=0 at 2b/2b requires exactly 256 beats before OUT_VALID.
